// File: rtl/ifu_pkg.sv
// Shared constants, entry type and sizing helper for the instruction fetch unit.
// Imported by the interface, the buffer FIFO and the fetch unit top.
package ifu_pkg;

   localparam int unsigned IFU_ADDR_W     = 6;
   localparam int unsigned IFU_FIFO_DEPTH = 4;
   localparam int unsigned IFU_RESET_PC   = 0;
   localparam int unsigned IFU_INST_W     = 32;
   localparam int unsigned IFU_PC_W       = IFU_ADDR_W + 2;

   typedef struct packed {
      logic [IFU_PC_W-1:0]   pc;
      logic [IFU_INST_W-1:0] inst;
   } ifu_entry_t;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int unsigned ifu_cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// ROM, redirect and instruction-delivery signals of the fetch unit.
// master = fetch unit side, slave = ROM/consumer/branch-unit side.
interface inst_fetch_unit_if
   import ifu_pkg::*;
#(
   parameter int unsigned ADDR_W = IFU_ADDR_W
);

   logic                  rom_en;
   logic [ADDR_W-1:0]     rom_addr;
   logic [IFU_INST_W-1:0] rom_data;
   logic                  redirect_valid;
   logic [ADDR_W+1:0]     redirect_pc;
   logic                  inst_valid;
   logic                  inst_ready;
   logic [IFU_INST_W-1:0] InstCode;
   logic [ADDR_W+1:0]     inst_pc;

   modport master (
      output rom_en, rom_addr, inst_valid, InstCode, inst_pc,
      input  rom_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  rom_en, rom_addr, inst_valid, InstCode, inst_pc,
      output rom_data, redirect_valid, redirect_pc, inst_ready
   );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous power-of-two FIFO with flush; flush overrides push and pop.
// Push while full is accepted only when a pop happens on the same edge.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int unsigned Depth = IFU_FIFO_DEPTH,
   parameter type         EntryT = ifu_entry_t
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  EntryT                         wdata,
   output logic [ifu_cnt_w(Depth)-1:0]   count,
   output EntryT                         head,
   output logic                          empty,
   output logic                          full
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = ifu_cnt_w(Depth);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   EntryT           mem_q [Depth];
   EntryT           mem_d [Depth];
   logic            do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(Depth));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: credit-throttled synchronous-ROM fetch into a small buffer.
// Define IFU_PERF_CNT_EN to add the fetch_cnt/stall_cnt performance counters.
module inst_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned ADDR_W     = IFU_ADDR_W,
   parameter int unsigned RESET_PC   = IFU_RESET_PC,
   parameter int unsigned FIFO_DEPTH = IFU_FIFO_DEPTH
) (
   input  logic                 Clka,
   input  logic                 Reset,
   inst_fetch_unit_if.master    bus
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]          fetch_cnt,
   output logic [31:0]          stall_cnt
`endif
);

   localparam int unsigned    PcW        = ADDR_W + 2;
   localparam int unsigned    CntW       = ifu_cnt_w(FIFO_DEPTH);
   localparam logic [PcW-1:0] ResetPcRaw = PcW'(RESET_PC);
   localparam logic [PcW-1:0] ResetPc    = {ResetPcRaw[PcW-1:2], 2'b00};

   typedef struct packed {
      logic [PcW-1:0]        pc;
      logic [IFU_INST_W-1:0] inst;
   } fetch_entry_t;

   logic [PcW-1:0]  pc_q, pc_d;
   logic [PcW-1:0]  req_pc_q, req_pc_d;
   logic            pending_q, pending_d;
   logic            issue;
   logic            pop;
   logic [CntW-1:0] fifo_count;
   logic            fifo_empty;
   logic            fifo_full;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;
   logic            unused_sig;

   // Credit check counts the in-flight read so the buffer can never overflow.
   assign issue = !Reset && !bus.redirect_valid &&
                  ((fifo_count + CntW'(pending_q)) < CntW'(FIFO_DEPTH));
   assign pop   = bus.inst_valid && bus.inst_ready;

   assign push_entry = '{pc: req_pc_q, inst: bus.rom_data};

   assign bus.rom_en     = issue;
   assign bus.rom_addr   = pc_q[PcW-1:2];
   assign bus.inst_valid = !fifo_empty;
   assign bus.InstCode   = head_entry.inst;
   assign bus.inst_pc    = head_entry.pc;

   assign unused_sig = ^{bus.redirect_pc[1:0], fifo_full};

   always_comb begin
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      pending_d = 1'b0;
      if (bus.redirect_valid) begin
         pc_d = {bus.redirect_pc[PcW-1:2], 2'b00};
      end else if (issue) begin
         pc_d      = pc_q + PcW'(4);
         req_pc_d  = pc_q;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge Clka or posedge Reset) begin
      if (Reset) begin
         pc_q      <= ResetPc;
         req_pc_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         req_pc_q  <= req_pc_d;
         pending_q <= pending_d;
      end
   end

   // Redirect drives flush, which drops both the buffer and the pending response.
   ifu_fifo #(
      .Depth  (FIFO_DEPTH),
      .EntryT (fetch_entry_t)
   ) u_fifo (
      .clk   (Clka),
      .rst   (Reset),
      .push  (pending_q),
      .pop   (pop),
      .flush (bus.redirect_valid),
      .wdata (push_entry),
      .count (fifo_count),
      .head  (head_entry),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + 32'(pop);
      stall_cnt_d = stall_cnt_q + 32'(bus.inst_valid && !bus.inst_ready);
   end

   always_ff @(posedge Clka or posedge Reset) begin
      if (Reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus random ready/redirect,
// with a queue-based model of the expected instruction stream checked by a monitor.
module tb_inst_fetch_unit;
   import ifu_pkg::*;

   localparam int unsigned    AddrW   = IFU_ADDR_W;
   localparam int unsigned    PcW     = AddrW + 2;
   localparam int unsigned    Depth   = IFU_FIFO_DEPTH;
   localparam logic [PcW-1:0] ResetPc = '0;

   logic        Clka  = 1'b0;
   logic        Reset = 1'b1;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   int unsigned pops        = 0;

   logic [PcW-1:0] exp_q [$];
   logic [PcW-1:0] model_next;
   int unsigned    since_redir = 100;

   inst_fetch_unit_if #(.ADDR_W(AddrW)) bus ();

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   inst_fetch_unit #(
      .ADDR_W     (AddrW),
      .RESET_PC   (0),
      .FIFO_DEPTH (Depth)
   ) dut (
      .Clka      (Clka),
      .Reset     (Reset),
      .bus       (bus)
`ifdef IFU_PERF_CNT_EN
      ,
      .fetch_cnt (fetch_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 Clka = ~Clka;

   function automatic logic [31:0] rom_word(input logic [AddrW-1:0] a);
      return 32'h1000_0000 + 32'(a);
   endfunction

   // Synchronous ROM: data appears the cycle after the request.
   always @(posedge Clka) begin
      if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // The consumer must see consecutive word addresses from the latest restart point.
   task automatic top_up();
      while (exp_q.size() < 8) begin
         exp_q.push_back(model_next);
         model_next = model_next + PcW'(4);
      end
   endtask

   task automatic restart(input logic [PcW-1:0] start);
      exp_q.delete();
      model_next = start;
      top_up();
   endtask

   always @(negedge Clka) begin : monitor
      logic [PcW-1:0] exp_pc;
      if (Reset) begin
         restart(ResetPc);
         pops        = 0;
         since_redir = 100;
      end else begin
         if (since_redir < 100) since_redir++;
         if (since_redir == 1 || since_redir == 2) check("redir_gap_valid", bus.inst_valid, 0);
         if (since_redir == 3) check("redir_latency_valid", bus.inst_valid, 1);
         if (bus.inst_valid && bus.inst_ready) begin
            exp_pc = exp_q.pop_front();
            check("pop_pc", 32'(bus.inst_pc), 32'(exp_pc));
            check("pop_inst", bus.InstCode, rom_word(exp_pc[PcW-1:2]));
            pops++;
            top_up();
         end
         if (bus.redirect_valid) begin
            check("redir_rom_en", bus.rom_en, 0);
            restart({bus.redirect_pc[PcW-1:2], 2'b00});
            since_redir = 0;
         end
      end
   end

   task automatic cycle();
      @(posedge Clka);
      #1;
   endtask

   task automatic neg();
      @(negedge Clka);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PcW-1:0] seen [$];
      logic [PcW-1:0] wrap_exp [4];

      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      Reset              = 1'b1;
      repeat (3) cycle();
      neg();
      check("rst_rom_en", bus.rom_en, 0);
      check("rst_rom_addr", 32'(bus.rom_addr), 32'(ResetPc[PcW-1:2]));
      check("rst_inst_valid", bus.inst_valid, 0);

      // Release with consumer ready: valid in cycle 2, then one per cycle.
      cycle();
      Reset          = 1'b0;
      bus.inst_ready = 1'b1;
      neg();
      check("c0_rom_en", bus.rom_en, 1);
      check("c0_valid", bus.inst_valid, 0);
      neg();
      check("c1_valid", bus.inst_valid, 0);
      for (int c = 2; c < 10; c++) begin
         neg();
         check("stream_valid", bus.inst_valid, 1);
         if (c == 2) begin
            check("first_pc", 32'(bus.inst_pc), 0);
            check("first_inst", bus.InstCode, 32'h1000_0000);
         end
      end

      // Consumer stalls: buffer fills to depth, fetch stops, head holds pc 0.
      cycle();
      Reset          = 1'b1;
      bus.inst_ready = 1'b0;
      cycle();
      Reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         neg();
         if (c == 11) begin
            check("stall_rom_en", bus.rom_en, 0);
            check("stall_valid", bus.inst_valid, 1);
            check("stall_head_pc", 32'(bus.inst_pc), 0);
            check("stall_head_inst", bus.InstCode, 32'h1000_0000);
         end
      end
      cycle();
      bus.inst_ready = 1'b1;
      repeat (8) cycle();
      bus.inst_ready = 1'b0;
      neg();
      check("drain_pops", pops, 8);
`ifdef IFU_PERF_CNT_EN
      check("perf_stall_cnt", stall_cnt, 10);
      check("perf_fetch_cnt", fetch_cnt, pops);
`endif

      // Redirect with 3 buffered and a read in flight.
      cycle();
      Reset = 1'b1;
      cycle();
      Reset = 1'b0;
      repeat (4) cycle();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = PcW'(8'h2B);
      neg();
      check("redir_busy_valid", bus.inst_valid, 1);
      cycle();
      bus.redirect_valid = 1'b0;
      bus.inst_ready     = 1'b1;
      neg();
      check("redir_flush_valid", bus.inst_valid, 0);
      check("redir_issue_en", bus.rom_en, 1);
      check("redir_issue_addr", 32'(bus.rom_addr), 10);
      neg();
      neg();
      check("redir_first_valid", bus.inst_valid, 1);
      check("redir_first_pc", 32'(bus.inst_pc), 32'h28);
      check("redir_first_inst", bus.InstCode, 32'h1000_000A);

      // Back-to-back redirects: only the second target is fetched.
      cycle();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = PcW'(8'h40);
      cycle();
      bus.redirect_pc    = PcW'(8'h80);
      cycle();
      bus.redirect_valid = 1'b0;
      repeat (6) cycle();

      // PC wrap at the top of the address space.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = PcW'(8'hF8);
      cycle();
      bus.redirect_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         neg();
         if (bus.inst_valid && bus.inst_ready) seen.push_back(bus.inst_pc);
      end
      wrap_exp[0] = PcW'(8'hF8);
      wrap_exp[1] = PcW'(8'hFC);
      wrap_exp[2] = PcW'(8'h00);
      wrap_exp[3] = PcW'(8'h04);
      check("wrap_seen_count", 32'(seen.size() >= 4), 1);
      for (int k = 0; k < 4; k++) begin
         if (k < seen.size()) check("wrap_pc", 32'(seen[k]), 32'(wrap_exp[k]));
      end

      // Asynchronous reset between edges with a full buffer.
      cycle();
      bus.inst_ready = 1'b0;
      repeat (8) cycle();
      @(posedge Clka);
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_valid", bus.inst_valid, 0);
      check("async_rst_rom_en", bus.rom_en, 0);
      @(posedge Clka);
      #1;
      Reset          = 1'b0;
      bus.inst_ready = 1'b1;
      neg();
      check("restart_rom_en", bus.rom_en, 1);
      check("restart_rom_addr", 32'(bus.rom_addr), 32'(ResetPc[PcW-1:2]));
      neg();
      neg();
      check("restart_valid", bus.inst_valid, 1);
      check("restart_pc", 32'(bus.inst_pc), 32'(ResetPc));

      // Random consumer backpressure and redirects.
      for (int i = 0; i < 400; i++) begin
         cycle();
         bus.inst_ready     = ($urandom_range(0, 9) < 7);
         bus.redirect_valid = ($urandom_range(0, 15) == 0);
         bus.redirect_pc    = PcW'($urandom);
      end
      cycle();
      bus.redirect_valid = 1'b0;
      bus.inst_ready     = 1'b0;
      repeat (4) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
- REQ-001: Parameter ADDR_W, default 6, ROM word-address width; the PC spans ADDR_W+2 bits, with bits [1:0] always 0.
- REQ-002: Parameter RESET_PC, default 0, byte address loaded into the PC on reset.
- REQ-003: Parameter FIFO_DEPTH, default 4, instruction buffer entries; the value SHALL be a power of 2 and at least 2.
- REQ-004: Clka  in  1  sole clock; all state updates on the rising edge.
- REQ-005: Reset  in  1  asynchronous, active-high reset.
- REQ-006: rom_en  out  1  ROM read request this cycle.
- REQ-007: rom_addr  out  ADDR_W  ROM word address, equal to PC[ADDR_W+1:2].
- REQ-008: rom_data  in  32  synchronous ROM output, valid one cycle after rom_en.
- REQ-009: redirect_valid  in  1  branch/jump redirect request.
- REQ-010: redirect_pc  in  ADDR_W+2  redirect target byte address.
- REQ-011: inst_valid  out  1  buffer head holds a valid instruction.
- REQ-012: inst_ready  in  1  consumer accepts the head instruction.
- REQ-013: InstCode  out  32  head instruction word.
- REQ-014: inst_pc  out  ADDR_W+2  byte address of the head instruction.

Function
- REQ-015: rom_en SHALL be 1 iff Reset=0, redirect_valid=0, and (fifo_count + pending) < FIFO_DEPTH; pending is a 1-bit in-flight read flag.
- REQ-016: On each issue, the PC SHALL advance by 4 modulo 2^(ADDR_W+2); it wraps from the top address to 0 without any flag.
- REQ-017: On the edge after an issue, pending SHALL be 1 and req_pc SHALL hold the issued PC; on the following edge, rom_data and req_pc SHALL be written into the FIFO.
- REQ-018: Latency SHALL be exactly 2 cycles from rom_en=1 to inst_valid=1 when the buffer starts empty, with no bypass path.
- REQ-019: Sustained throughput SHALL be 1 instruction per cycle while inst_ready=1.
- REQ-020: inst_valid SHALL equal FIFO not-empty; InstCode and inst_pc SHALL be the head entry and stay stable while inst_valid=1 and inst_ready=0.
- REQ-021: A pop SHALL occur on an edge where inst_valid=1 and inst_ready=1.
- REQ-022: Simultaneous push and pop SHALL be legal at any occupancy, including full.
- REQ-023: redirect_valid=1 SHALL, on the same edge:
  - flush the FIFO, so inst_valid=0 next cycle;
  - discard any pending read response;
  - load PC <= {redirect_pc[ADDR_W+1:2], 2'b00}, silently ignoring bits [1:0].
- REQ-024: A handshake completed in the same cycle as a redirect SHALL count as consumed, and the redirect SHALL take priority over all pushes.
- REQ-025: The first issue after a redirect SHALL occur in the next cycle at the new PC; redirect-to-inst_valid latency SHALL be 3 cycles.
- REQ-026: Back-to-back redirects SHALL each take effect, with only the last target fetched.
- REQ-027: The FIFO SHALL never overflow; the credit rule in REQ-015 guarantees that a full FIFO with pending=0 gives rom_en=0.

Reset
- REQ-028: Reset=1 SHALL asynchronously set PC=RESET_PC, pending=0, FIFO empty, inst_valid=0, and all counters 0.
- REQ-029: During reset rom_en SHALL be 0 and rom_addr SHALL be RESET_PC[ADDR_W+1:2].
- REQ-030: Reset asserted mid-operation SHALL discard the buffer contents and the in-flight read.
- REQ-031: Fetching SHALL resume at RESET_PC on the first edge after deassertion.

Configuration
- REQ-032: Macro IFU_PERF_CNT_EN, when defined, SHALL add two outputs:
  - fetch_cnt (out, 32): counts pops;
  - stall_cnt (out, 32): counts cycles with inst_valid=1 and inst_ready=0.
- REQ-033: Both counters SHALL wrap at 2^32 and have no reset value other than 0.
- REQ-034: Without IFU_PERF_CNT_EN, fetch_cnt and stall_cnt SHALL be absent and no counter logic SHALL exist.

Structure
- REQ-035: Package ifu_pkg SHALL hold:
  - default constants IFU_ADDR_W=6, IFU_FIFO_DEPTH=4, IFU_RESET_PC=0;
  - constant IFU_INST_W=32;
  - typedef ifu_entry_t = {pc, inst}.
- REQ-036: Sub-module ifu_fifo SHALL be a parametrised synchronous FIFO with:
  - ports push, pop, flush, count, head, empty, full;
  - flush taking priority over push and pop.

Verification
- REQ-037: Reset release, ROM[i]=32'h1000_0000+i, inst_ready=1 -> inst_valid rises in cycle 2; inst_pc = 0, 4, 8, ... with 1 per cycle; InstCode = 1000_0000, 1000_0001, ...
- REQ-038: inst_ready=0 for 10 cycles -> exactly 4 entries buffered, rom_en=0 once count+pending=4, head stays pc 0; after inst_ready=1, entries pop in order with no loss or duplicates.
- REQ-039: redirect_valid=1, redirect_pc=0x2B, while 3 entries are buffered and a read is pending -> inst_valid=0 next cycle; the first instruction after the redirect is inst_pc=0x28, InstCode=ROM[10], 3 cycles after the redirect.
- REQ-040: Free-run from PC=0xF8 with ADDR_W=6 -> inst_pc sequence F8, FC, 00, 04.
- REQ-041: Reset pulse asserted between edges with a full FIFO -> inst_valid=0 and rom_en=0 immediately; fetch restarts at RESET_PC.
- REQ-042: With IFU_PERF_CNT_EN defined, run REQ-038 -> stall_cnt=10 and fetch_cnt equals the number of pops.
